// File: rtl/idex_pipe_buf.sv
// idex_pipe_buf: ID/EX stage register with valid/ready handshake, optional skid entry, bubble kill, flush and saturating stall counter
module idex_pipe_buf #(
  parameter int CTRL_W = 13,
  parameter int DATA_W = 148,
  parameter logic [CTRL_W-1:0] KILL_MASK = CTRL_W'('h0060),
  parameter int SKID = 1,
  parameter int CNT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [CTRL_W-1:0] i_in_ctrl,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_nop,
  input  logic              i_flush,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [CTRL_W-1:0] o_out_ctrl,
  output logic [DATA_W-1:0] o_out_data,
  output logic [CNT_W-1:0]  o_stall_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t            r_state;
  logic [CTRL_W-1:0] r_main_ctrl, r_skid_ctrl, w_in_ctrl;
  logic [DATA_W-1:0] r_main_data, r_skid_data;
  logic              w_acc, w_del, w_stall;
  always_comb begin
    o_in_ready  = (SKID != 0) ? (r_state != TWO) : (r_state == EMPTY || i_out_ready);
    o_out_valid = r_state != EMPTY;
    o_out_ctrl  = o_out_valid ? r_main_ctrl : '0;
    o_out_data  = r_main_data;
    w_acc       = i_in_valid && o_in_ready;
    w_del       = o_out_valid && i_out_ready;
    w_stall     = o_out_valid && !i_out_ready;
    w_in_ctrl   = i_in_nop ? (i_in_ctrl & ~KILL_MASK) : i_in_ctrl;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= EMPTY;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
      o_stall_cnt <= '0;
    end else begin
      o_stall_cnt <= o_stall_cnt + CNT_W'(w_stall && !(&o_stall_cnt));
      if (i_flush) begin
        r_state     <= EMPTY;
        r_main_ctrl <= '0;
        r_skid_ctrl <= '0;
      end else if (r_state == EMPTY) begin
        if (w_acc) begin
          r_state     <= ONE;
          r_main_ctrl <= w_in_ctrl;
          r_main_data <= i_in_data;
        end
      end else if (r_state == ONE) begin
        if (w_acc && w_del) begin
          r_main_ctrl <= w_in_ctrl;
          r_main_data <= i_in_data;
        end else if (w_acc) begin
          r_state     <= TWO;
          r_skid_ctrl <= w_in_ctrl;
          r_skid_data <= i_in_data;
        end else if (w_del) begin
          r_state <= EMPTY;
        end
      end else if (w_del) begin
        r_state     <= ONE;
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
    end
  end
endmodule

// File: tb/tb_idex_pipe_buf.sv
// tb_idex_pipe_buf: directed plus random checks of both buffer variants against a queue model
module tb_idex_pipe_buf;
  localparam int CW = 13;
  localparam int DW = 148;
  logic          clk = 0, rst_n = 0, in_valid = 0, in_nop = 0, flush = 0, out_ready = 0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          rdy [2];
  logic          ov [2];
  logic [CW-1:0] oc [2];
  logic [DW-1:0] od [2];
  logic [15:0]   sc0;
  logic [1:0]    sc1;
  logic [CW-1:0] mc [2][2];
  logic [DW-1:0] md [2][2];
  int            n [2] = '{0, 0};
  int            cnt [2] = '{0, 0};
  int            cap [2] = '{2, 1};
  int            cmax [2] = '{65535, 3};
  int            checks = 0, errors = 0;
  logic          acc0;
  logic [DW-1:0] tmp;
  always #5 clk = ~clk;
  idex_pipe_buf u_skid (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(rdy[0]),
    .i_in_ctrl(in_ctrl), .i_in_data(in_data), .i_in_nop(in_nop), .i_flush(flush),
    .o_out_valid(ov[0]), .i_out_ready(out_ready), .o_out_ctrl(oc[0]), .o_out_data(od[0]),
    .o_stall_cnt(sc0)
  );
  idex_pipe_buf #(.SKID(0), .CNT_W(2)) u_reg (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(rdy[1]),
    .i_in_ctrl(in_ctrl), .i_in_data(in_data), .i_in_nop(in_nop), .i_flush(flush),
    .o_out_valid(ov[1]), .i_out_ready(out_ready), .o_out_ctrl(oc[1]), .o_out_data(od[1]),
    .o_stall_cnt(sc1)
  );
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [DW-1:0] rnd();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction
  function automatic logic mrdy(input int k);
    return n[k] < cap[k] || (k == 1 && out_ready);
  endfunction
  task automatic step();
    logic a [2];
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("in_ready%0d", k), rdy[k], mrdy(k));
      a[k] = in_valid && mrdy(k);
    end
    acc0 = a[0];
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        n[k] = 0;
        cnt[k] = 0;
      end else begin
        if (n[k] > 0 && !out_ready && cnt[k] < cmax[k]) cnt[k]++;
        if (flush) n[k] = 0;
        else begin
          if (n[k] > 0 && out_ready) begin
            mc[k][0] = mc[k][1];
            md[k][0] = md[k][1];
            n[k]--;
          end
          if (a[k]) begin
            mc[k][n[k]] = in_nop ? (in_ctrl & ~13'h0060) : in_ctrl;
            md[k][n[k]] = in_data;
            n[k]++;
          end
        end
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("out_valid%0d", k), ov[k], n[k] > 0);
      chk($sformatf("out_ctrl%0d", k), oc[k], n[k] > 0 ? mc[k][0] : '0);
      if (n[k] > 0) chk($sformatf("out_data%0d", k), od[k], md[k][0]);
    end
    chk("stall_cnt0", sc0, cnt[0]);
    chk("stall_cnt1", sc1, cnt[1]);
  endtask
  initial begin
    step();
    step();
    chk("rst_data0", od[0], '0);
    chk("rst_data1", od[1], '0);
    rst_n = 1;
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1;
      in_ctrl = CW'(i);
      tmp = rnd();
      in_data = {32'(4 * (i - 1)), tmp[115:0]};
      step();
      chk("stream_ctrl", oc[0], i);
      chk("stream_pc", od[0][147:116], 4 * (i - 1));
    end
    in_valid = 0;
    step();
    chk("stream_stall", sc0, 0);
    out_ready = 0;
    in_valid = 1;
    for (int b = 0; b < 3; b++) begin
      in_ctrl = CW'(20 + b);
      in_data = rnd();
      for (int t = 0; t < 8; t++) begin
        if (b == 2 && t == 3) out_ready = 1;
        step();
        if (acc0) break;
      end
      if (b == 1) chk("bp_skid_full", rdy[0], 1'b0);
    end
    in_valid = 0;
    repeat (3) step();
    in_valid = 1;
    in_nop = 1;
    in_ctrl = 13'h1FFF;
    in_data = rnd();
    step();
    chk("nop_ctrl", oc[0], 13'h1F9F);
    chk("nop_data", od[0], in_data);
    in_nop = 0;
    in_valid = 0;
    step();
    out_ready = 0;
    in_valid = 1;
    repeat (2) begin
      in_ctrl = CW'($urandom());
      in_data = rnd();
      step();
    end
    flush = 1;
    in_ctrl = 13'h0ABC;
    in_data = rnd();
    step();
    chk("flush_valid", ov[0], 1'b0);
    chk("flush_ctrl", oc[0], '0);
    chk("flush_ready", rdy[0], 1'b1);
    flush = 0;
    in_ctrl = 13'h0123;
    in_data = rnd();
    step();
    chk("post_flush_ctrl", oc[0], 13'h0123);
    in_valid = 0;
    out_ready = 1;
    repeat (2) step();
    out_ready = 0;
    in_valid = 1;
    repeat (2) begin
      in_ctrl = CW'($urandom());
      in_data = rnd();
      step();
    end
    rst_n = 0;
    step();
    chk("rst_mid_valid", ov[0], 1'b0);
    chk("rst_mid_stall", sc0, 0);
    chk("rst_mid_data", od[0], '0);
    rst_n = 1;
    in_ctrl = 13'h0042;
    in_data = rnd();
    step();
    in_valid = 0;
    #1;
    chk("reg_ready_eq", rdy[1], out_ready);
    repeat (5) step();
    chk("sat_cnt1", sc1, 2'd3);
    chk("stall_cnt0_5", sc0, 16'd5);
    out_ready = 1;
    step();
    repeat (400) begin
      in_valid = ($urandom() % 4) != 0;
      out_ready = ($urandom() % 3) != 0;
      in_nop = ($urandom() % 8) == 0;
      flush = ($urandom() % 20) == 0;
      rst_n = ($urandom() % 50) != 0;
      in_ctrl = CW'($urandom());
      in_data = rnd();
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
